// File: rtl/weight_rotate_register.sv
// weight_rotate_register: serially loaded weight bank with circular rotation and fill tracking
module weight_rotate_register #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int CNT_W = 4
) (
    input  logic                   CLK,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   shift_en,
    input  logic                   rotate_en,
    input  logic [WIDTH-1:0]       D,
    output logic [WIDTH-1:0]       Q,
    output logic [WIDTH*DEPTH-1:0] Q_all,
    output logic [CNT_W-1:0]       count,
    output logic                   full,
    output logic                   empty,
    output logic                   overflow,
    output logic                   rot_done
);
    logic [WIDTH*DEPTH-1:0] mem, nxt, sh;
    logic [CNT_W-1:0]       cnt, cnt_n, ptr, ptr_n, last;
    logic                   ovf_n, rd_n;

    assign sh   = mem >> WIDTH;
    assign last = cnt - 1'b1;

    // State register: entries, fill level, rotation phase and event pulses
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            mem      <= '0;
            cnt      <= '0;
            ptr      <= '0;
            overflow <= 1'b0;
            rot_done <= 1'b0;
        end else begin
            mem      <= nxt;
            cnt      <= cnt_n;
            ptr      <= ptr_n;
            overflow <= ovf_n;
            rot_done <= rd_n;
        end
    end

    // Next state: clear beats load beats rotate; one operation per cycle
    always_comb begin
        nxt   = mem;
        cnt_n = cnt;
        ptr_n = ptr;
        ovf_n = 1'b0;
        rd_n  = 1'b0;
        if (clear) begin
            nxt   = '0;
            cnt_n = '0;
            ptr_n = '0;
        end else if (shift_en) begin
            if (full) begin
                ovf_n = 1'b1;
            end else begin
                for (int i = 0; i < DEPTH; i++)
                    if (CNT_W'(i) == cnt) nxt[i*WIDTH +: WIDTH] = D;
                cnt_n = cnt + 1'b1;
                ptr_n = '0;
            end
        end else if (rotate_en && !empty) begin
            for (int i = 0; i < DEPTH; i++)
                if (CNT_W'(i) == last) nxt[i*WIDTH +: WIDTH] = mem[WIDTH-1:0];
                else if (CNT_W'(i) < last) nxt[i*WIDTH +: WIDTH] = sh[i*WIDTH +: WIDTH];
            rd_n  = ptr == last;
            ptr_n = rd_n ? '0 : ptr + 1'b1;
        end
    end

    assign Q     = mem[WIDTH-1:0];
    assign Q_all = mem;
    assign count = cnt;
    assign full  = cnt == CNT_W'(DEPTH);
    assign empty = cnt == '0;
endmodule

// File: tb/tb_weight_rotate_register.sv
// tb_weight_rotate_register: table vectors plus scoreboarded reference model for the weight bank
module tb_weight_rotate_register;
    localparam int W = 32;
    localparam int N = 8;
    localparam int C = 4;

    logic             CLK = 0, reset = 1, clear = 0, shift_en = 0, rotate_en = 0;
    logic [W-1:0]     D = '0;
    logic [W-1:0]     Q;
    logic [W*N-1:0]   Q_all;
    logic [C-1:0]     count;
    logic             full, empty, overflow, rot_done;

    weight_rotate_register #(.WIDTH(W), .DEPTH(N), .CNT_W(C)) dut (
        .CLK(CLK), .reset(reset), .clear(clear), .shift_en(shift_en), .rotate_en(rotate_en),
        .D(D), .Q(Q), .Q_all(Q_all), .count(count), .full(full), .empty(empty),
        .overflow(overflow), .rot_done(rot_done)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [W-1:0]   q;
        logic [W*N-1:0] all;
        int             cnt;
        logic           fl, em, ov, rd;
    } exp_t;

    typedef struct {
        logic         sh, rot;
        logic [W-1:0] d;
        logic [W-1:0] q;
        int           cnt;
        logic         rd;
    } vec_t;

    exp_t         sb[$];
    vec_t         tbl[7];
    logic [W-1:0] m[N];
    int           mc, mp;
    logic         mo, mr;
    int           total = 0, bad = 0;

    task automatic chk(input string name, input logic [W*N-1:0] act, input logic [W*N-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m[i] = '0;
        mc = 0; mp = 0; mo = 0; mr = 0;
    endtask

    task automatic model_step(input logic c, input logic s, input logic r, input logic [W-1:0] d);
        logic [W-1:0] t;
        mo = 0; mr = 0;
        if (c) model_reset();
        else if (s) begin
            if (mc == N) mo = 1;
            else begin m[mc] = d; mc++; mp = 0; end
        end else if (r && mc > 0) begin
            t = m[0];
            for (int i = 0; i < mc - 1; i++) m[i] = m[i+1];
            m[mc-1] = t;
            if (mp == mc - 1) begin mp = 0; mr = 1; end
            else mp++;
        end
    endtask

    function automatic exp_t model_exp();
        exp_t e;
        e.q = m[0];
        e.all = '0;
        for (int i = 0; i < N; i++) e.all[i*W +: W] = m[i];
        e.cnt = mc; e.fl = (mc == N); e.em = (mc == 0); e.ov = mo; e.rd = mr;
        return e;
    endfunction

    task automatic step(input logic c, input logic s, input logic r, input logic [W-1:0] d);
        exp_t e;
        clear = c; shift_en = s; rotate_en = r; D = d;
        model_step(c, s, r, d);
        sb.push_back(model_exp());
        @(posedge CLK);
        #1;
        clear = 0; shift_en = 0; rotate_en = 0;
        e = sb.pop_front();
        chk("q", Q, e.q);
        chk("q_all", Q_all, e.all);
        chk("count", count, e.cnt);
        chk("full", full, e.fl);
        chk("empty", empty, e.em);
        chk("overflow", overflow, e.ov);
        chk("rot_done", rot_done, e.rd);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_q"}, Q, 0);
        chk({tag, "_q_all"}, Q_all, 0);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_empty"}, empty, 1);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_overflow"}, overflow, 0);
        chk({tag, "_rot_done"}, rot_done, 0);
    endtask

    initial begin
        tbl[0] = '{1, 0, 1, 1, 1, 0};
        tbl[1] = '{1, 0, 2, 1, 2, 0};
        tbl[2] = '{1, 0, 3, 1, 3, 0};
        tbl[3] = '{0, 1, 0, 2, 3, 0};
        tbl[4] = '{0, 1, 0, 3, 3, 0};
        tbl[5] = '{0, 1, 0, 1, 3, 1};
        tbl[6] = '{0, 0, 0, 1, 3, 0};

        model_reset();
        #1;
        check_zero("por");
        repeat (2) @(posedge CLK);
        #1 reset = 0;

        // load 3, rotate 3: table-driven
        for (int k = 0; k < 7; k++) begin
            step(0, tbl[k].sh, tbl[k].rot, tbl[k].d);
            chk("tbl_q", Q, tbl[k].q);
            chk("tbl_count", count, tbl[k].cnt);
            chk("tbl_rot_done", rot_done, tbl[k].rd);
        end
        chk("tbl_upper_zero", Q_all[W*N-1:3*W], 0);

        // async reset mid-operation with count=5
        step(0, 1, 0, 4); step(0, 1, 0, 5);
        chk("pre_reset_count", count, 5);
        #2 reset = 1;
        #1 check_zero("async");
        model_reset();
        @(posedge CLK);
        #1 reset = 0;

        // fill to full then overflow
        for (int k = 0; k < N; k++) step(0, 1, 0, 10 + k);
        chk("full_flag", full, 1);
        step(0, 1, 0, 99);
        chk("ovf_pulse", overflow, 1);
        chk("ovf_count", count, N);
        step(0, 0, 0, 0);
        chk("ovf_gone", overflow, 0);
        step(0, 1, 1, 98);
        chk("ovf_both", overflow, 1);
        chk("ovf_both_norot", Q, 10);

        // load after partial rotation
        step(1, 0, 0, 0);
        step(0, 1, 0, 1); step(0, 1, 0, 2); step(0, 1, 0, 3);
        step(0, 0, 1, 0);
        step(0, 1, 0, 4);
        chk("ext_order", Q_all[4*W-1:0], {32'd4, 32'd1, 32'd3, 32'd2});
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 1, 0);
            chk("ext_no_rd", rot_done, 0);
        end
        step(0, 0, 1, 0);
        chk("ext_rd", rot_done, 1);
        chk("ext_restored", Q_all[4*W-1:0], {32'd4, 32'd1, 32'd3, 32'd2});

        // load and rotate together; rotate while empty
        step(1, 0, 0, 0);
        step(0, 1, 0, 8); step(0, 1, 0, 9);
        step(0, 1, 1, 7);
        chk("both_r2", Q_all[3*W-1:2*W], 7);
        chk("both_q", Q, 8);
        chk("both_rd", rot_done, 0);
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        chk("empty_rot_rd", rot_done, 0);
        chk("empty_rot_all", Q_all, 0);

        // single entry rotation, then clear
        step(0, 1, 0, 5);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 1, 0);
            chk("one_q", Q, 5);
            chk("one_rd", rot_done, 1);
        end
        step(1, 0, 0, 0);
        check_zero("clear");

        // random mix against the model
        for (int k = 0; k < 300; k++)
            step($urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, $urandom);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
